// File: rtl/pd_seq_pkg.sv
// Shared definitions for the GPIO pattern sequencer: opcodes, config map,
// PIO register offsets and the sequencer state encoding.
package pd_seq_pkg;

  localparam int DEPTH_MAX     = 8;
  localparam int DUR_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    OP_WRITE     = 2'd0,
    OP_SET       = 2'd1,
    OP_CLEAR     = 2'd2,
    OP_WAIT_EDGE = 2'd3
  } opcode_e;

  localparam logic [4:0] CFG_CTRL       = 5'd0;
  localparam logic [4:0] CFG_STATUS     = 5'd1;
  localparam logic [4:0] CFG_NUM_STEPS  = 5'd2;
  localparam logic [4:0] CFG_LOOP_COUNT = 5'd3;

  // Step table banks, selected by cfg_address[4:3].
  localparam logic [1:0] CFG_BANK_VALUE = 2'b01;
  localparam logic [1:0] CFG_BANK_CTRL  = 2'b10;

  localparam logic [2:0] PIO_DATA  = 3'd0;
  localparam logic [2:0] PIO_EDGE  = 3'd3;
  localparam logic [2:0] PIO_SET   = 3'd4;
  localparam logic [2:0] PIO_CLEAR = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_HOLD,
    ST_POLL,
    ST_POLL_WAIT,
    ST_ACK,
    ST_DONE
  } state_e;

endpackage

// File: rtl/pd_seq_step_table.sv
// Step table: per-entry value and control words, written and read back over
// the config slave, with a combinational fetch port for the sequencer.
module pd_seq_step_table
  import pd_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_MAX,
  parameter int DUR_W = DUR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [4:0]       rd_addr,
  output logic [31:0]      rd_data,
  input  logic [2:0]       fetch_idx,
  output logic [31:0]      fetch_value,
  output logic [1:0]       fetch_op,
  output logic [DUR_W-1:0] fetch_dur
);

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  logic [31:0] value_mem [DEPTH];
  logic [31:0] ctrl_mem  [DEPTH];
  logic        wr_ok, rd_ok, fetch_ok;

  assign wr_ok    = ({1'b0, wr_addr[2:0]} < DEPTH_L);
  assign rd_ok    = ({1'b0, rd_addr[2:0]} < DEPTH_L);
  assign fetch_ok = ({1'b0, fetch_idx} < DEPTH_L);

  // NOTE: the table is small flops, not RAM, so it is reset like any other
  // register; the reset loop would block RAM inference if DEPTH ever grew.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        value_mem[i] <= '0;
        ctrl_mem[i]  <= '0;
      end
    end else if (wr_en && wr_ok) begin
      if (wr_addr[4:3] == CFG_BANK_VALUE) value_mem[wr_addr[2:0]] <= wr_data;
      else if (wr_addr[4:3] == CFG_BANK_CTRL) ctrl_mem[wr_addr[2:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (rd_ok) begin
      if (rd_addr[4:3] == CFG_BANK_VALUE) rd_data = value_mem[rd_addr[2:0]];
      else if (rd_addr[4:3] == CFG_BANK_CTRL) rd_data = ctrl_mem[rd_addr[2:0]];
    end
  end

  always_comb begin
    fetch_value = '0;
    fetch_op    = '0;
    fetch_dur   = '0;
    if (fetch_ok) begin
      fetch_value = value_mem[fetch_idx];
      fetch_op    = ctrl_mem[fetch_idx][31:30];
      fetch_dur   = ctrl_mem[fetch_idx][DUR_W-1:0];
    end
  end

endmodule

// File: rtl/pd_gpio_sequencer.sv
// Autonomous pattern sequencer: runs a CPU-loaded step table against a PIO's
// Avalon-MM slave, issuing data/set/clear writes and polling edge_capture.
module pd_gpio_sequencer
  import pd_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_MAX,
  parameter int DUR_W = DUR_W_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  cfg_address,
  input  logic        cfg_chipselect,
  input  logic        cfg_write_n,
  input  logic [31:0] cfg_writedata,
  output logic [31:0] cfg_readdata,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        irq
);

  localparam logic [3:0] DEPTH_L = 4'(DEPTH);

  logic             cfg_wr, start, stop;
  logic             loop_en, irq_en;
  logic [3:0]       num_steps;
  logic [15:0]      loop_count;

  state_e           state, state_a, state_next;
  logic             busy, busy_next, done, done_next, timeout, timeout_next;
  logic [2:0]       idx, idx_next;
  logic [15:0]      loops, loops_next, loops_sat;
  logic [DUR_W-1:0] dur_cnt, dur_cnt_next;
  logic [DUR_W-1:0] poll_cnt, poll_cnt_a, poll_cnt_next, poll_cnt_inc;
  logic [DUR_W-1:0] cur_dur, cur_dur_next;
  logic [31:0]      cur_value, cur_value_next;
  logic             enter_step, advance, last_step, loop_again;

  logic             cs_a, we_n_a, cs_next, we_n_next;
  logic [2:0]       addr_a, addr_next;
  logic [31:0]      data_a, data_next;

  logic [31:0]      tbl_rd_data, fetch_value, rd_mux;
  logic [1:0]       fetch_op;
  logic [DUR_W-1:0] fetch_dur;

  assign cfg_wr = cfg_chipselect & ~cfg_write_n;
  assign start  = cfg_wr && (cfg_address == CFG_CTRL) && cfg_writedata[0];
  assign stop   = cfg_wr && (cfg_address == CFG_CTRL) && cfg_writedata[1];
  assign irq    = (done | timeout) & irq_en;

  pd_seq_step_table #(.DEPTH(DEPTH), .DUR_W(DUR_W)) u_table (
    .clk         (clk),
    .reset_n     (reset_n),
    .wr_en       (cfg_wr),
    .wr_addr     (cfg_address),
    .wr_data     (cfg_writedata),
    .rd_addr     (cfg_address),
    .rd_data     (tbl_rd_data),
    .fetch_idx   (idx_next),
    .fetch_value (fetch_value),
    .fetch_op    (fetch_op),
    .fetch_dur   (fetch_dur)
  );

  // NOTE: state is updated with <= only; blocking assignments here would let
  // later statements in the same edge see half-updated registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loop_en    <= 1'b0;
      irq_en     <= 1'b0;
      num_steps  <= '0;
      loop_count <= '0;
    end else if (cfg_wr) begin
      case (cfg_address)
        CFG_CTRL: begin
          loop_en <= cfg_writedata[2];
          irq_en  <= cfg_writedata[3];
        end
        CFG_NUM_STEPS:  num_steps  <= (cfg_writedata[3:0] > DEPTH_L) ? DEPTH_L : cfg_writedata[3:0];
        CFG_LOOP_COUNT: loop_count <= cfg_writedata[15:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    case (cfg_address)
      CFG_CTRL:       rd_mux = {28'd0, irq_en, loop_en, 2'b00};
      CFG_STATUS:     rd_mux = {loops, 5'd0, idx, 5'd0, timeout, done, busy};
      CFG_NUM_STEPS:  rd_mux = {28'd0, num_steps};
      CFG_LOOP_COUNT: rd_mux = {16'd0, loop_count};
      default:        rd_mux = tbl_rd_data;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cfg_readdata <= '0;
    else if (cfg_chipselect && cfg_write_n) cfg_readdata <= rd_mux;
  end

  assign last_step    = (({1'b0, idx} + 4'd1) >= num_steps);
  assign loops_sat    = (loops == 16'hFFFF) ? loops : loops + 16'd1;
  assign loop_again   = loop_en && ((loop_count == 16'd0) ||
                        (({1'b0, loops} + 17'd1) < {1'b0, loop_count}));
  assign poll_cnt_inc = poll_cnt + DUR_W'(1);

  // Sequencing decisions; the step being entered is decoded separately below
  // because its table fetch depends on idx_next.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_a      = state;
    idx_next     = idx;
    loops_next   = loops;
    busy_next    = busy;
    done_next    = done;
    timeout_next = timeout;
    dur_cnt_next = dur_cnt;
    poll_cnt_a   = poll_cnt;
    enter_step   = 1'b0;
    advance      = 1'b0;
    cs_a         = 1'b0;
    we_n_a       = 1'b1;
    addr_a       = m_address;
    data_a       = m_writedata;

    if (stop) begin
      state_a   = ST_IDLE;
      busy_next = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (num_steps != 4'd0) begin
              idx_next     = '0;
              loops_next   = '0;
              done_next    = 1'b0;
              timeout_next = 1'b0;
              busy_next    = 1'b1;
              enter_step   = 1'b1;
            end else begin
              done_next = 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (cur_dur == '0) advance = 1'b1;
          else begin
            state_a      = ST_HOLD;
            dur_cnt_next = cur_dur - DUR_W'(1);
          end
        end
        ST_HOLD: begin
          if (dur_cnt == '0) advance = 1'b1;
          else dur_cnt_next = dur_cnt - DUR_W'(1);
        end
        ST_POLL: state_a = ST_POLL_WAIT;
        ST_POLL_WAIT: begin
          if ((m_readdata & cur_value) != 32'd0) begin
            state_a = ST_ACK;
            cs_a    = 1'b1;
            we_n_a  = 1'b0;
            addr_a  = PIO_EDGE;
            data_a  = cur_value;
          end else if ((cur_dur != '0) && (poll_cnt_inc == cur_dur)) begin
            state_a      = ST_DONE;
            timeout_next = 1'b1;
            done_next    = 1'b1;
            busy_next    = 1'b0;
          end else begin
            state_a    = ST_POLL;
            poll_cnt_a = poll_cnt_inc;
            cs_a       = 1'b1;
            addr_a     = PIO_EDGE;
          end
        end
        ST_ACK:  advance = 1'b1;
        ST_DONE: state_a = ST_IDLE;
        default: state_a = ST_IDLE;
      endcase

      if (advance) begin
        if (!last_step) begin
          idx_next   = idx + 3'd1;
          enter_step = 1'b1;
        end else begin
          loops_next = loops_sat;
          if (loop_again) begin
            idx_next   = '0;
            enter_step = 1'b1;
          end else begin
            state_a   = ST_DONE;
            done_next = 1'b1;
            busy_next = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    state_next     = state_a;
    cs_next        = cs_a;
    we_n_next      = we_n_a;
    addr_next      = addr_a;
    data_next      = data_a;
    cur_value_next = cur_value;
    cur_dur_next   = cur_dur;
    poll_cnt_next  = poll_cnt_a;
    if (enter_step) begin
      cur_value_next = fetch_value;
      cur_dur_next   = fetch_dur;
      poll_cnt_next  = '0;
      cs_next        = 1'b1;
      case (opcode_e'(fetch_op))
        OP_WAIT_EDGE: begin
          state_next = ST_POLL;
          we_n_next  = 1'b1;
          addr_next  = PIO_EDGE;
        end
        OP_SET: begin
          state_next = ST_ISSUE;
          we_n_next  = 1'b0;
          addr_next  = PIO_SET;
          data_next  = fetch_value;
        end
        OP_CLEAR: begin
          state_next = ST_ISSUE;
          we_n_next  = 1'b0;
          addr_next  = PIO_CLEAR;
          data_next  = fetch_value;
        end
        default: begin
          state_next = ST_ISSUE;
          we_n_next  = 1'b0;
          addr_next  = PIO_DATA;
          data_next  = fetch_value;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      idx          <= '0;
      loops        <= '0;
      dur_cnt      <= '0;
      poll_cnt     <= '0;
      cur_dur      <= '0;
      cur_value    <= '0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= '0;
      m_writedata  <= '0;
    end else begin
      state        <= state_next;
      busy         <= busy_next;
      done         <= done_next;
      timeout      <= timeout_next;
      idx          <= idx_next;
      loops        <= loops_next;
      dur_cnt      <= dur_cnt_next;
      poll_cnt     <= poll_cnt_next;
      cur_dur      <= cur_dur_next;
      cur_value    <= cur_value_next;
      m_chipselect <= cs_next;
      m_write_n    <= we_n_next;
      m_address    <= addr_next;
      m_writedata  <= data_next;
    end
  end

endmodule

// File: tb/tb_pd_gpio_sequencer.sv
// Directed bench for pd_gpio_sequencer with a small behavioural PIO model
// that logs master writes and answers edge_capture reads.
module tb_pd_gpio_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [4:0]  cfg_address = '0;
  logic        cfg_chipselect = 1'b0;
  logic        cfg_write_n = 1'b1;
  logic [31:0] cfg_writedata = '0;
  logic [31:0] cfg_readdata;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  logic [31:0] rd_q = '0;
  logic        irq;

  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         wlog[$];
  int          cyc = 0;
  int          n_reads = 0;
  int          irq_rise = -1;
  logic        irq_prev = 1'b0;
  logic [31:0] edge_reg = '0;
  logic [31:0] edge_in = '0;
  int          n_tests = 0;
  int          n_fail = 0;

  pd_gpio_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cfg_address    (cfg_address),
    .cfg_chipselect (cfg_chipselect),
    .cfg_write_n    (cfg_write_n),
    .cfg_writedata  (cfg_writedata),
    .cfg_readdata   (cfg_readdata),
    .m_address      (m_address),
    .m_chipselect   (m_chipselect),
    .m_write_n      (m_write_n),
    .m_writedata    (m_writedata),
    .m_readdata     (rd_q),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  // PIO model: logs writes, counts reads, edge bits set by edge_in and
  // cleared by writes of 1s to offset 3; read data returned one cycle later.
  always @(posedge clk) begin
    logic [31:0] clr;
    clr = '0;
    cyc <= cyc + 1;
    if (m_chipselect && !m_write_n) begin
      wlog.push_back('{cyc: cyc, addr: m_address, data: m_writedata});
      if (m_address == 3'd3) clr = m_writedata;
    end
    if (m_chipselect && m_write_n) begin
      n_reads <= n_reads + 1;
      rd_q    <= edge_reg;
    end
    edge_reg <= (edge_reg | edge_in) & ~clr;
  end

  always @(negedge clk) begin
    irq_prev <= irq;
    if (irq && !irq_prev) irq_rise <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic wr_t log_at(int i);
    wr_t r;
    r.cyc  = -1000;
    r.addr = '0;
    r.data = '0;
    if (i >= 0 && i < wlog.size()) r = wlog[i];
    return r;
  endfunction

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_chipselect = 1'b1;
    cfg_write_n    = 1'b0;
    cfg_address    = a;
    cfg_writedata  = d;
    @(negedge clk);
    cfg_chipselect = 1'b0;
    cfg_write_n    = 1'b1;
  endtask

  task automatic cfg_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    cfg_chipselect = 1'b1;
    cfg_write_n    = 1'b1;
    cfg_address    = a;
    @(posedge clk);
    #1;
    d = cfg_readdata;
    cfg_chipselect = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_edge(input logic [31:0] m);
    @(negedge clk);
    edge_in = m;
    @(negedge clk);
    edge_in = '0;
  endtask

  initial begin
    logic [31:0] rd;
    int b, r0;
    wr_t e0, e1, e2;

    #12;
    check("rst_cs", 32'(m_chipselect), 32'd0);
    check("rst_wn", 32'(m_write_n), 32'd1);
    check("rst_addr", 32'(m_address), 32'd0);
    check("rst_data", m_writedata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", cfg_readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cfg_read(5'd1, rd);
    check("rst_status", rd, 32'd0);

    // Two-step WRITE then CLEAR, with irq enabled.
    cfg_write(5'd2, 32'd15);
    cfg_read(5'd2, rd);
    check("num_clamp", rd, 32'd8);
    cfg_write(5'd2, 32'd2);
    cfg_write(5'd8, 32'hA5A5_A5A5);
    cfg_write(5'd16, 32'h0000_0003);
    cfg_write(5'd9, 32'h0000_0005);
    cfg_write(5'd17, 32'h8000_0000);
    cfg_read(5'd17, rd);
    check("tbl_readback", rd, 32'h8000_0000);
    cfg_read(5'd24, rd);
    check("unmapped_rd", rd, 32'd0);
    b = wlog.size();
    cfg_write(5'd0, 32'h9);
    wait_cycles(15);
    e0 = log_at(b);
    e1 = log_at(b + 1);
    check("t1_nwr", 32'(wlog.size() - b), 32'd2);
    check("t1_a0", 32'(e0.addr), 32'd0);
    check("t1_d0", e0.data, 32'hA5A5_A5A5);
    check("t1_a1", 32'(e1.addr), 32'd5);
    check("t1_d1", e1.data, 32'h5);
    check("t1_gap", 32'(e1.cyc - e0.cyc), 32'd4);
    check("t1_irq_t", 32'(irq_rise - e0.cyc), 32'd5);
    check("t1_irq", 32'(irq), 32'd1);
    cfg_read(5'd1, rd);
    check("t1_status", rd, 32'h0001_0102);

    // Looping single SET step, three passes.
    cfg_write(5'd2, 32'd1);
    cfg_write(5'd8, 32'h1);
    cfg_write(5'd16, 32'h4000_0000);
    cfg_write(5'd3, 32'd3);
    b = wlog.size();
    cfg_write(5'd0, 32'h5);
    wait_cycles(15);
    e0 = log_at(b);
    e1 = log_at(b + 1);
    e2 = log_at(b + 2);
    check("t2_nwr", 32'(wlog.size() - b), 32'd3);
    check("t2_addr", {23'd0, e0.addr, e1.addr, e2.addr}, {23'd0, 3'd4, 3'd4, 3'd4});
    check("t2_data", e0.data | e1.data | e2.data, 32'h1);
    check("t2_gap", 32'((e1.cyc - e0.cyc) * 10 + (e2.cyc - e1.cyc)), 32'd11);
    check("t2_irq_off", 32'(irq), 32'd0);
    cfg_read(5'd1, rd);
    check("t2_status", rd, 32'h0003_0002);

    // WAIT_EDGE on bit 2, with an unrelated bit 1 already captured.
    cfg_write(5'd2, 32'd2);
    cfg_write(5'd8, 32'h4);
    cfg_write(5'd16, 32'hC000_0000);
    cfg_write(5'd9, 32'h77);
    cfg_write(5'd17, 32'h0000_0000);
    b  = wlog.size();
    r0 = n_reads;
    cfg_write(5'd0, 32'h1);
    pulse_edge(32'h2);
    wait_cycles(10);
    check("t3_no_wr", 32'(wlog.size() - b), 32'd0);
    pulse_edge(32'h4);
    wait_cycles(15);
    e0 = log_at(b);
    e1 = log_at(b + 1);
    check("t3_polls", 32'((n_reads - r0) >= 5), 32'd1);
    check("t3_nwr", 32'(wlog.size() - b), 32'd2);
    check("t3_ack", {e0.data[28:0], e0.addr}, {29'h4, 3'd3});
    check("t3_next", {e1.data[28:0], e1.addr}, {29'h77, 3'd0});
    check("t3_gap", 32'(e1.cyc - e0.cyc), 32'd1);
    check("t3_edge", edge_reg, 32'h2);
    cfg_read(5'd1, rd);
    check("t3_status", rd, 32'h0001_0102);

    // WAIT_EDGE timeout after five polls.
    cfg_write(5'd2, 32'd1);
    cfg_write(5'd8, 32'h1);
    cfg_write(5'd16, 32'hC000_0005);
    b  = wlog.size();
    r0 = n_reads;
    cfg_write(5'd0, 32'h9);
    wait_cycles(30);
    check("t4_reads", 32'(n_reads - r0), 32'd5);
    check("t4_nwr", 32'(wlog.size() - b), 32'd0);
    check("t4_irq", 32'(irq), 32'd1);
    cfg_read(5'd1, rd);
    check("t4_status", rd, 32'h0000_0006);

    // Stop during a long HOLD; a second start while busy is ignored.
    cfg_write(5'd2, 32'd2);
    cfg_write(5'd8, 32'h11);
    cfg_write(5'd16, 32'h0000_0064);
    cfg_write(5'd9, 32'h22);
    cfg_write(5'd17, 32'h0000_0000);
    b = wlog.size();
    cfg_write(5'd0, 32'h1);
    wait_cycles(5);
    cfg_write(5'd0, 32'h1);
    wait_cycles(5);
    cfg_write(5'd0, 32'h2);
    check("t5_cs", 32'(m_chipselect), 32'd0);
    cfg_read(5'd1, rd);
    check("t5_status", rd, 32'd0);
    wait_cycles(110);
    check("t5_nwr", 32'(wlog.size() - b), 32'd1);
    b = wlog.size();
    cfg_write(5'd0, 32'h1);
    wait_cycles(115);
    e0 = log_at(b);
    e1 = log_at(b + 1);
    check("t5_restart", e0.data, 32'h11);
    check("t5_step1", e1.data, 32'h22);
    check("t5_gap", 32'(e1.cyc - e0.cyc), 32'd101);
    cfg_read(5'd1, rd);
    check("t5_done", rd, 32'h0001_0102);

    // start and stop together: nothing happens.
    b  = wlog.size();
    r0 = n_reads;
    cfg_write(5'd0, 32'h3);
    wait_cycles(10);
    check("t6_nwr", 32'((wlog.size() - b) + (n_reads - r0)), 32'd0);
    cfg_read(5'd1, rd);
    check("t6_status", rd, 32'h0001_0102);

    // Reset asserted mid-HOLD.
    b = wlog.size();
    cfg_write(5'd0, 32'h1);
    wait_cycles(5);
    reset_n = 1'b0;
    #1;
    check("t7_cs", 32'(m_chipselect), 32'd0);
    check("t7_wn", 32'(m_write_n), 32'd1);
    check("t7_addr", 32'(m_address), 32'd0);
    check("t7_data", m_writedata, 32'd0);
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(110);
    check("t7_nwr", 32'(wlog.size() - b), 32'd1);
    cfg_read(5'd1, rd);
    check("t7_status", rd, 32'd0);
    cfg_read(5'd8, rd);
    check("t7_tbl", rd, 32'd0);
    cfg_read(5'd2, rd);
    check("t7_num", rd, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pd_gpio_sequencer.md
Name: pd_gpio_sequencer

Overview:
Autonomous pattern sequencer that drives the 32-bit pattern/GPIO PIO through that PIO's Avalon-MM slave port, so pattern steps run without CPU involvement. The CPU loads a step table and control registers through a config slave. The sequencer then acts as the single master of the PIO slave, issuing data, set and clear writes and polling edge_capture. It sits between the CPU interconnect and the PIO instance in the pattern generator system.

Parameters:
DEPTH, 8, number of step-table entries; fixed by the config address map, maximum 8.
DUR_W, 24, width of the per-step duration/poll-limit field.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_address  in  5  config slave word address
cfg_chipselect  in  1  config slave select
cfg_write_n  in  1  config write strobe, active low
cfg_writedata  in  32  config write data
cfg_readdata  out  32  config read data; registered, 1-cycle latency
m_address  out  3  PIO slave address
m_chipselect  out  1  PIO slave select
m_write_n  out  1  PIO write strobe, active low
m_writedata  out  32  PIO write data
m_readdata  in  32  PIO read data; valid 1 cycle after the read cycle
irq  out  1  (done|timeout) & irq_en

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, reset_n.
- Reset values:
  - cfg_readdata=0, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, irq=0.
  - All control/status registers = 0. Table contents = 0.
  - FSM = IDLE.
- Config map (config write = cfg_chipselect & ~cfg_write_n):
  - 0 CTRL (write): bit0 start, bit1 stop (both self-clearing pulses); bit2 loop_en, bit3 irq_en (stored).
  - 1 STATUS (read): bit0 busy, bit1 done, bit2 timeout, [10:8] step index, [31:16] loops completed.
  - 2 NUM_STEPS: [3:0], valid range 1..DEPTH; values above DEPTH are clamped to DEPTH.
  - 3 LOOP_COUNT: [15:0]; 0 means loop forever.
  - 8..15 STEP_VALUE[i]: 32 bits.
  - 16..23 STEP_CTRL[i]: [31:30] opcode, [DUR_W-1:0] duration.
  - Unmapped reads return 0.
- Opcodes:
  - 0 WRITE: write value to PIO addr 0.
  - 1 SET: write value to PIO addr 4.
  - 2 CLEAR: write value to PIO addr 5.
  - 3 WAIT_EDGE: poll PIO addr 3 until (m_readdata & value)!=0.
- FSM states: IDLE, ISSUE, HOLD, POLL, POLL_WAIT, ACK, DONE.
- Master outputs are registered and valid exactly in the cycle the FSM is in ISSUE, POLL or ACK; otherwise chipselect=0 and write_n=1.
- IDLE:
  - start with NUM_STEPS!=0 → idx=0, loops=0, done and timeout cleared, busy=1.
  - Next state is ISSUE or POLL according to the step's opcode.
  - start with NUM_STEPS=0 → set done only.
- ISSUE: one write cycle using the table entry read in this cycle.
  - duration D=0 → advance next cycle.
  - Otherwise HOLD for D cycles.
  - Consecutive write steps therefore begin exactly 1+D cycles apart.
- POLL: one read cycle at address 3. POLL_WAIT then samples m_readdata.
  - Hit → ACK: write address 3 with writedata=value to clear the edge, then advance.
  - Miss with D!=0 and poll count == D → set timeout, go to DONE (abort).
  - Otherwise re-enter POLL. A poll cycle is therefore 2 cycles.
- Advance:
  - idx<NUM_STEPS-1 → idx+1.
  - Otherwise loops+1. If loop_en and (LOOP_COUNT==0 or loops+1<LOOP_COUNT) → idx=0; else DONE.
  - The loops counter saturates at 0xFFFF.
- DONE: set done, busy=0, return to IDLE on the next cycle.
- stop (or reset): FSM → IDLE on the next clock; busy=0, done unchanged.
  - The PIO is left holding its last output value.
  - An in-flight read is discarded; it is harmless.
- Simultaneous events:
  - start and stop in the same write → stop wins.
  - start while busy is ignored.
- Table writes while busy are permitted and take effect the next time that entry is fetched.

Decomposition:
- Shared package pd_seq_pkg holds:
  - opcode encodings;
  - config register addresses;
  - PIO register offsets (0 data, 3 edge, 4 set, 5 clear);
  - FSM state enum;
  - DUR_W default.
- Sub-module pd_seq_step_table: DEPTH×(32+32) register file. It has a config write port, a config read port and a combinational fetch port indexed by idx.

Test Plan:
- NUM_STEPS=2: step0 WRITE 0xA5A5A5A5 D=3, step1 CLEAR 0x5 D=0; start → addr0 write at cycle t, addr5 write at t+4, done set at t+5 and irq raised if irq_en.
- loop_en=1, LOOP_COUNT=3, single SET 0x1 D=0 → exactly 3 writes to addr4 on consecutive cycles; STATUS[31:16]=3; done=1.
- WAIT_EDGE value 0x4, D=0; PIO edge bit2 asserted after 10 cycles → polls continue until hit, then one addr3 write with data 0x4, then next step.
- WAIT_EDGE value 0x1, D=5, no edge → exactly 5 reads, timeout=1, done=1, no ACK write.
- Stop written during a HOLD of D=100 → m_chipselect low from the next cycle; busy=0; restart runs from idx 0.
- start+stop in one CTRL write, and reset_n asserted mid-HOLD → no master cycle issued; all outputs at reset values.
